// File: rtl/counter_mod_n.sv
// Modulo-N up/down counter with synchronous clear, clamped parallel load, wrap or
// saturate behaviour at the range ends, and a zero-latency terminal count for cascading.
module counter_mod_n #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 10,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             vld,
    output logic             tc,
    output logic             ovf,
    output logic             ld_err
);

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);
    // One extra bit so MODULUS == 2**WIDTH is representable for the range check.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

    logic             at_term;
    logic             clamp;
    logic [WIDTH-1:0] cnt_nxt;
    logic             vld_nxt;
    logic             ovf_nxt;
    logic             ld_err_nxt;

    function automatic logic [WIDTH-1:0] step_cnt(input logic [WIDTH-1:0] c,
                                                  input logic             up,
                                                  input logic             term);
        if (term)
            return SATURATE ? c : (up ? '0 : MAX_CNT);
        return up ? c + 1'b1 : c - 1'b1;
    endfunction

    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v,
                                                    input logic             over);
        return over ? MAX_CNT : v;
    endfunction

    always_comb begin
        at_term = up_dn ? (cnt == MAX_CNT) : (cnt == '0);
        clamp   = {1'b0, load_val} >= MOD_EXT;
        tc      = rst & en & ~clr & ~load & at_term;
    end

    // Priority: clr, then load, then en; at most one action per edge.
    always_comb begin
        cnt_nxt    = cnt;
        vld_nxt    = 1'b0;
        ovf_nxt    = ovf;
        ld_err_nxt = 1'b0;
        if (clr) begin
            cnt_nxt = '0;
            ovf_nxt = 1'b0;
        end else if (load) begin
            cnt_nxt    = clamp_load(load_val, clamp);
            vld_nxt    = 1'b1;
            ld_err_nxt = clamp;
        end else if (en) begin
            cnt_nxt = step_cnt(cnt, up_dn, at_term);
            vld_nxt = 1'b1;
            if (at_term)
                ovf_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            vld    <= 1'b0;
            ovf    <= 1'b0;
            ld_err <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            vld    <= vld_nxt;
            ovf    <= ovf_nxt;
            ld_err <= ld_err_nxt;
        end
    end

endmodule

// File: tb/tb_counter_mod_n.sv
// Bench for counter_mod_n: wrap (4b/10), saturate (4b/10) and binary (3b/8) instances
// share one stimulus stream; a reference model feeds a scoreboard queue per step.
module tb_counter_mod_n;

    typedef struct {
        int cnt;
        bit vld;
        bit ovf;
        bit lerr;
        bit tc;
    } exp_t;

    typedef struct {
        bit cl;
        bit ld;
        bit en;
        bit up;
        int lv;
        int cnt;
        bit vld;
        bit tc;
        bit ovf;
        bit lerr;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       up_dn;
    logic       clr;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] cnt0;
    logic [3:0] cnt1;
    logic [2:0] cnt2;
    logic [2:0] vld_o;
    logic [2:0] tc_o;
    logic [2:0] ovf_o;
    logic [2:0] lerr_o;

    int   checks   = 0;
    int   failures = 0;
    int   mods[3]  = '{10, 10, 8};
    bit   sats[3]  = '{1'b0, 1'b1, 1'b0};
    int   wids[3]  = '{4, 4, 3};
    exp_t st[3];
    exp_t q[$];
    bit   tc_pre[3];
    vec_t tbl[$];

    always #5 clk = ~clk;

    counter_mod_n #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .cnt(cnt0), .vld(vld_o[0]), .tc(tc_o[0]),
        .ovf(ovf_o[0]), .ld_err(lerr_o[0]));

    counter_mod_n #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_sat (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val), .cnt(cnt1), .vld(vld_o[1]), .tc(tc_o[1]),
        .ovf(ovf_o[1]), .ld_err(lerr_o[1]));

    counter_mod_n #(.WIDTH(3), .MODULUS(8), .SATURATE(1'b0)) u_bin (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
        .load_val(load_val[2:0]), .cnt(cnt2), .vld(vld_o[2]), .tc(tc_o[2]),
        .ovf(ovf_o[2]), .ld_err(lerr_o[2]));

    function automatic exp_t model(input int m, input bit sat, input int w, input exp_t s,
                                   input bit cl, input bit ld, input bit e, input bit u,
                                   input int lv);
        exp_t r;
        bit   term;
        int   v;
        v      = lv % (1 << w);
        term   = u ? (s.cnt == m - 1) : (s.cnt == 0);
        r      = s;
        r.vld  = 1'b0;
        r.lerr = 1'b0;
        r.tc   = e && !cl && !ld && term;
        if (cl) begin
            r.cnt = 0;
            r.ovf = 1'b0;
        end else if (ld) begin
            r.vld  = 1'b1;
            r.lerr = (v >= m);
            r.cnt  = (v >= m) ? m - 1 : v;
        end else if (e) begin
            r.vld = 1'b1;
            if (term) r.ovf = 1'b1;
            if (!(term && sat)) r.cnt = (s.cnt + (u ? 1 : m - 1)) % m;
        end
        return r;
    endfunction

    function automatic logic [31:0] get_cnt(input int k);
        case (k)
            0:       return 32'(cnt0);
            1:       return 32'(cnt1);
            default: return 32'(cnt2);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic add(input bit cl, input bit ld, input bit e, input bit u, input int lv,
                       input int c, input bit v, input bit t, input bit o, input bit le);
        vec_t r;
        r.cl = cl; r.ld = ld; r.en = e; r.up = u; r.lv = lv;
        r.cnt = c; r.vld = v; r.tc = t; r.ovf = o; r.lerr = le;
        tbl.push_back(r);
    endtask

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic do_step(input bit cl, input bit ld, input bit e, input bit u, input int lv);
        exp_t nx[3];
        exp_t x;
        clr = cl; load = ld; en = e; up_dn = u; load_val = 4'(lv);
        for (int k = 0; k < 3; k++) begin
            nx[k] = model(mods[k], sats[k], wids[k], st[k], cl, ld, e, u, lv);
            q.push_back(nx[k]);
            st[k] = nx[k];
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            tc_pre[k] = tc_o[k];
            chk($sformatf("tc[%0d]", k), 32'(tc_o[k]), 32'(nx[k].tc));
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            x = q.pop_front();
            chk($sformatf("cnt[%0d]", k),    get_cnt(k),        32'(x.cnt));
            chk($sformatf("vld[%0d]", k),    32'(vld_o[k]),     32'(x.vld));
            chk($sformatf("ovf[%0d]", k),    32'(ovf_o[k]),     32'(x.ovf));
            chk($sformatf("ld_err[%0d]", k), 32'(lerr_o[k]),    32'(x.lerr));
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b0; en = 1'b1; up_dn = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0;
        for (int k = 0; k < 3; k++) st[k] = '{default: 0};

        // Count up through wrap, clamped load, priority, enable gaps, down wrap, reversal.
        for (int i = 1; i <= 9; i++) add(0, 0, 1, 1, 0, i, 1, 0, 0, 0);
        add(0, 0, 1, 1, 0,  0, 1, 1, 1, 0);
        add(0, 0, 1, 1, 0,  1, 1, 0, 1, 0);
        add(0, 0, 1, 1, 0,  2, 1, 0, 1, 0);
        add(0, 1, 0, 1, 13, 9, 1, 0, 1, 1);
        add(0, 1, 0, 1, 4,  4, 1, 0, 1, 0);
        add(0, 1, 0, 1, 7,  7, 1, 0, 1, 0);
        add(1, 1, 1, 1, 2,  0, 0, 0, 0, 0);
        add(0, 1, 1, 1, 6,  6, 1, 0, 0, 0);
        add(0, 1, 0, 1, 3,  3, 1, 0, 0, 0);
        add(0, 0, 1, 1, 0,  4, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0,  4, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0,  4, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0,  5, 1, 0, 0, 0);
        add(0, 1, 0, 1, 0,  0, 1, 0, 0, 0);
        add(0, 0, 1, 0, 0,  9, 1, 1, 1, 0);
        add(0, 0, 1, 0, 0,  8, 1, 0, 1, 0);
        add(0, 0, 1, 1, 0,  9, 1, 0, 1, 0);
        add(0, 0, 1, 0, 0,  8, 1, 0, 1, 0);
        add(0, 0, 0, 1, 0,  8, 0, 0, 1, 0);
        add(0, 1, 0, 1, 9,  9, 1, 0, 1, 0);
        add(0, 0, 0, 1, 0,  9, 0, 0, 1, 0);

        #12;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_cnt[%0d]", k), get_cnt(k),     32'd0);
            chk($sformatf("rst_vld[%0d]", k), 32'(vld_o[k]),  32'd0);
            chk($sformatf("rst_ovf[%0d]", k), 32'(ovf_o[k]),  32'd0);
            chk($sformatf("rst_lerr[%0d]", k), 32'(lerr_o[k]), 32'd0);
            chk($sformatf("rst_tc[%0d]", k),  32'(tc_o[k]),   32'd0);
        end
        en = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        foreach (tbl[i]) begin
            do_step(tbl[i].cl, tbl[i].ld, tbl[i].en, tbl[i].up, tbl[i].lv);
            chk($sformatf("tbl%0d_cnt", i),  get_cnt(0),        32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_vld", i),  32'(vld_o[0]),     32'(tbl[i].vld));
            chk($sformatf("tbl%0d_tc", i),   32'(tc_pre[0]),    32'(tbl[i].tc));
            chk($sformatf("tbl%0d_ovf", i),  32'(ovf_o[0]),     32'(tbl[i].ovf));
            chk($sformatf("tbl%0d_lerr", i), 32'(lerr_o[0]),    32'(tbl[i].lerr));
        end

        // Saturating instance holds at 0 when stepping down from terminal.
        do_step(1, 0, 0, 1, 0);
        do_step(0, 0, 1, 0, 0);
        chk("sat_cnt", get_cnt(1),     32'd0);
        chk("sat_ovf", 32'(ovf_o[1]),  32'd1);
        chk("sat_vld", 32'(vld_o[1]),  32'd1);
        chk("sat_tc",  32'(tc_pre[1]), 32'd1);
        chk("wrap_dn", get_cnt(0),     32'd9);

        // Binary-modulus instance rolls 7 -> 0 with tc asserted at 7.
        do_step(0, 1, 0, 1, 6);
        do_step(0, 0, 1, 1, 0);
        chk("bin_cnt7", get_cnt(2), 32'd7);
        do_step(0, 0, 1, 1, 0);
        chk("bin_tc7",  32'(tc_pre[2]), 32'd1);
        chk("bin_cnt0", get_cnt(2),     32'd0);
        chk("bin_ovf",  32'(ovf_o[2]),  32'd1);

        // Asynchronous reset between edges, counting resumes on the first edge after release.
        do_step(0, 1, 0, 0, 5);
        chk("pre_rst_cnt", get_cnt(0), 32'd5);
        en = 1'b1; up_dn = 1'b0; clr = 1'b0; load = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("async_cnt",  get_cnt(0),    32'd0);
        chk("async_vld",  32'(vld_o[0]), 32'd0);
        chk("async_ovf",  32'(ovf_o[0]), 32'd0);
        chk("async_lerr", 32'(lerr_o[0]), 32'd0);
        for (int k = 0; k < 3; k++)
            chk($sformatf("async_tc[%0d]", k), 32'(tc_o[k]), 32'd0);
        for (int k = 0; k < 3; k++) st[k] = '{default: 0};
        @(posedge clk);
        #1;
        chk("held_rst_cnt", get_cnt(0), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        do_step(0, 0, 1, 1, 0);
        chk("release_cnt", get_cnt(0), 32'd1);

        for (int i = 0; i < 200; i++)
            do_step($urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                    int'($urandom_range(0, 15)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter_mod_n.md
COUNTER_MOD_N -- requirements
Module: counter_mod_n

Interface
REQ-001 Parameter WIDTH, default 4: count register width in bits.
REQ-002 Parameter MODULUS, default 10: count range 0..MODULUS-1; legal range 2..2^WIDTH.
REQ-003 Parameter SATURATE, default 0: 0 = wrap at range ends, 1 = hold at range ends.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  count enable; one step per clock while high.
REQ-007 up_dn  input  1  direction: 1 = increment, 0 = decrement; sampled only when a step occurs.
REQ-008 clr  input  1  synchronous clear to 0.
REQ-009 load  input  1  synchronous parallel load.
REQ-010 load_val  input  WIDTH  value for load.
REQ-011 cnt  output  WIDTH  registered count value.
REQ-012 vld  output  1  registered; high for the cycle after cnt was written by a step or load.
REQ-013 tc  output  1  combinational terminal-count/carry for cascading.
REQ-014 ovf  output  1  registered sticky flag: range end reached and crossed (wrap) or hit (saturate).
REQ-015 ld_err  output  1  registered one-cycle pulse: out-of-range load_val was clamped.

Function
REQ-016 Per-edge priority SHALL be: clr, then load, then en; at most one action per cycle.
REQ-017 clr=1 SHALL set cnt=0, vld=0, ovf=0, ld_err=0, regardless of load/en.
REQ-018 load=1 (clr=0) with load_val<MODULUS SHALL set cnt=load_val, vld=1, ld_err=0.
REQ-019 load=1 (clr=0) with load_val>=MODULUS SHALL set cnt=MODULUS-1, vld=1, ld_err=1 for exactly one cycle.
REQ-020 en=1, clr=0, load=0, not at terminal SHALL set cnt=cnt+1 (up_dn=1) or cnt-1 (up_dn=0), vld=1.
REQ-021 Terminal SHALL be cnt==MODULUS-1 when up_dn=1 and cnt==0 when up_dn=0.
REQ-022 Step at terminal with SATURATE=0 SHALL wrap (MODULUS-1 -> 0 up, 0 -> MODULUS-1 down), set vld=1, set ovf=1.
REQ-023 Step at terminal with SATURATE=1 SHALL hold cnt, set vld=1, set ovf=1.
REQ-024 No action in a cycle (clr=load=en=0) SHALL hold cnt and ovf and drive vld=0, ld_err=0.
REQ-025 tc SHALL equal en & ~clr & ~load & (cnt at terminal for current up_dn); zero latency; no glitch-sensitive use inside the block.
REQ-026 ovf SHALL remain 1 once set until clr or reset; load SHALL NOT clear it.
REQ-027 ld_err SHALL be 0 in every cycle that is not a clamped load.
REQ-028 Arithmetic SHALL be unsigned WIDTH-bit; cnt SHALL never leave 0..MODULUS-1.
REQ-029 Direction reversal SHALL take effect on the first step after up_dn changes, with no extra delay cycle.
REQ-030 MODULUS==2^WIDTH SHALL behave identically to natural binary roll-over, with tc and ovf as above.

Reset
REQ-031 rst=0 SHALL immediately, without a clock, force cnt=0, vld=0, ovf=0, ld_err=0.
REQ-032 Reset mid-count SHALL abort the current cycle; the first update SHALL occur on the first rising edge with rst=1.
REQ-033 tc SHALL be 0 while rst=0.

Verification (WIDTH=4, MODULUS=10 unless stated)
REQ-034 Reset, en=1, up_dn=1 for 12 edges -> cnt 1..9,0,1,2; tc high while cnt=9; ovf=1 from the wrap edge; vld=1 throughout.
REQ-035 load=1, load_val=13 -> cnt=9, ld_err=1 for one cycle then 0; load_val=4 -> cnt=4, ld_err=0.
REQ-036 cnt=0, en=1, up_dn=0 -> cnt=9, ovf=1; with SATURATE=1 -> cnt stays 0, ovf=1, vld=1.
REQ-037 Same edge clr=1, load=1, en=1 at cnt=7 -> cnt=0, vld=0, ovf=0; then load+en together -> load wins.
REQ-038 rst=0 asserted between edges while cnt=5 -> cnt=0 immediately; en high at release -> cnt=1 on first edge.
REQ-039 en toggled 1,0,0,1 from cnt=3 -> cnt 4,4,4,5; vld 1,0,0,1; WIDTH=3, MODULUS=8 -> 7 -> 0 roll-over with tc at 7.
